// File: rtl/mmio_delay_fifo.sv
// Fixed-depth shift-register delay FIFO between the MMIO write decoder and read mux.
// Optional running-sum output enabled by defining MMIO_DELAY_FIFO_SUM_EN.
module mmio_delay_fifo #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 16,
  parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q,
  output logic              q_valid,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic [DROP_W-1:0] dropped
`ifdef MMIO_DELAY_FIFO_SUM_EN
  ,
  output logic [WIDTH+CW-1:0] sum
`endif
);

  localparam int unsigned SW = WIDTH + CW;

  logic [WIDTH-1:0] entry [DEPTH];
  logic [CW-1:0]    count_r;
  logic             full_r;

  // Shift chain: entry[0] takes the new word, entry[DEPTH-1] falls off when full
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else if (en) begin
      entry[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) entry[i] <= entry[i-1];
    end
  end

  // Occupancy and drop status; full is kept as its own flop so outputs are register taps
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_r <= '0;
      full_r  <= 1'b0;
      dropped <= '0;
    end else if (en) begin
      if (!full_r) begin
        count_r <= count_r + CW'(1);
        full_r  <= (count_r == CW'(DEPTH - 1));
      end else if (dropped != {DROP_W{1'b1}}) begin
        dropped <= dropped + DROP_W'(1);
      end
    end
  end

`ifdef MMIO_DELAY_FIFO_SUM_EN
  // Exact running sum of valid entries; SW bits cannot overflow for DEPTH words
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + SW'(d) - (full_r ? SW'(entry[DEPTH-1]) : SW'(0));
    end
  end
`endif

  assign q       = entry[DEPTH-1];
  assign q_valid = full_r;
  assign full    = full_r;
  assign count   = count_r;

endmodule
